// File: rtl/interrupt_controller.sv
// Interrupt controller: owns IF/IE, latches source rising edges, and completes
// the CPU acknowledge handshake by clearing the serviced flag and supplying its vector.
module interrupt_controller #(
  parameter logic [15:0] IF_ADDR     = 16'hFF0F,
  parameter logic [15:0] IE_ADDR     = 16'hFFFF,
  parameter logic [7:0]  VECTOR_BASE = 8'h40
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  input  logic [15:0] i_Address,
  input  logic        i_Address_Out,
  input  logic [7:0]  i_Bus,
  input  logic        i_Bus_Out,
  input  logic        i_Bus_In,
  input  logic        i_Handle_Interrupt,
  input  logic [4:0]  i_Sources,
  output logic [7:0]  o_Bus,
  output logic [4:0]  o_Interrupts,
  output logic [7:0]  o_Ack_Vector
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t      state_r, state_next_s;
  logic [4:0]  if_r, if_next_s;
  logic [7:0]  ie_r;
  logic [4:0]  hist_r;
  logic [15:0] addr_r;
  logic [2:0]  ack_idx_r;
  logic        ack_valid_r;
  logic [15:0] eff_addr_s;
  logic        sel_if_s, sel_ie_s;
  logic        ack_take_s;
  logic [4:0]  pending_s;
  logic [4:0]  rise_s;

  // Index of the lowest set bit; callers only use it when some bit is set.
  function automatic logic [2:0] lowest_bit(input logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign eff_addr_s = i_Address_Out ? i_Address : addr_r;
  assign sel_if_s   = (eff_addr_s == IF_ADDR);
  assign sel_ie_s   = (eff_addr_s == IE_ADDR);
  assign pending_s  = if_r & ie_r[4:0];
  assign rise_s     = i_Sources & ~hist_r;
  assign o_Interrupts = pending_s;

  // Read mux; the bus is ORed by the CPU so unselected reads drive zero.
  always_comb begin
    o_Bus = 8'h00;
    if (i_Rst || !i_Bus_In) begin
      o_Bus = 8'h00;
    end else if (sel_if_s) begin
      o_Bus = {3'b111, if_r};
    end else if (sel_ie_s) begin
      o_Bus = ie_r;
    end else begin
      o_Bus = 8'h00;
    end
  end

  // Acknowledge FSM next state; a capture happens only on the IDLE->ACK edge.
  always_comb begin
    state_next_s = state_r;
    ack_take_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_Enable && i_Handle_Interrupt) begin
          state_next_s = ACK;
          ack_take_s   = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACK: begin
        if (i_Enable && !i_Handle_Interrupt) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ACK;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // IF update order: write, then acknowledge clear, then source set (last wins).
  always_comb begin
    if_next_s = if_r;
    if (i_Bus_Out && sel_if_s) begin
      if_next_s = i_Bus[4:0];
    end else begin
      if_next_s = if_r;
    end
    if (ack_take_s && (pending_s != 5'd0)) begin
      if_next_s[lowest_bit(pending_s)] = 1'b0;
    end else begin
      if_next_s = if_next_s;
    end
    if_next_s = if_next_s | rise_s;
  end

  // Service vector is only meaningful while acknowledging a real request.
  always_comb begin
    o_Ack_Vector = 8'h00;
    if (state_r == ACK && ack_valid_r) begin
      o_Ack_Vector = VECTOR_BASE + {2'b00, ack_idx_r, 3'b000};
    end else begin
      o_Ack_Vector = 8'h00;
    end
  end

  // State register; every update is qualified by the clock enable.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r     <= IDLE;
      if_r        <= 5'd0;
      ie_r        <= 8'h00;
      hist_r      <= 5'd0;
      addr_r      <= 16'h0000;
      ack_idx_r   <= 3'd0;
      ack_valid_r <= 1'b0;
    end else if (i_Enable) begin
      state_r <= state_next_s;
      if_r    <= if_next_s;
      hist_r  <= i_Sources;
      if (i_Address_Out) begin
        addr_r <= i_Address;
      end
      if (i_Bus_Out && sel_ie_s) begin
        ie_r <= i_Bus;
      end
      if (ack_take_s) begin
        ack_idx_r   <= lowest_bit(pending_s);
        ack_valid_r <= (pending_s != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] addr;
  logic        addr_out;
  logic [7:0]  bus_w;
  logic        bus_out;
  logic        bus_in;
  logic        handle;
  logic [4:0]  src;
  logic [7:0]  bus_r;
  logic [4:0]  irq;
  logic [7:0]  vec;

  int checks = 0;
  int failures = 0;

  interrupt_controller dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Address(addr),
    .i_Address_Out(addr_out), .i_Bus(bus_w), .i_Bus_Out(bus_out),
    .i_Bus_In(bus_in), .i_Handle_Interrupt(handle), .i_Sources(src),
    .o_Bus(bus_r), .o_Interrupts(irq), .o_Ack_Vector(vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
    addr = a; addr_out = 1'b1; bus_w = d; bus_out = 1'b1;
    tick();
    addr_out = 1'b0; bus_out = 1'b0; bus_w = 8'h00;
  endtask

  task automatic check_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr = a; addr_out = 1'b1; bus_in = 1'b1;
    #1;
    check(tag, bus_r, exp);
    bus_in = 1'b0; addr_out = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; addr = 16'h0000; addr_out = 1'b0; bus_w = 8'h00;
    bus_out = 1'b0; bus_in = 1'b0; handle = 1'b0; src = 5'd0;
    #12;
    check("reset_irq", {3'b000, irq}, 8'h00);
    check("reset_vec", vec, 8'h00);
    rst = 1'b0;
    #1;
    check_read("reset_if", 16'hFF0F, 8'hE0);
    check_read("reset_ie", 16'hFFFF, 8'h00);

    // 1: IE=1F, single-cycle pulse on source 2
    write_reg(16'hFFFF, 8'h1F);
    check_read("ie_rd", 16'hFFFF, 8'h1F);
    src = 5'b00100; tick(); src = 5'b00000; tick();
    check_read("t1_if", 16'hFF0F, 8'hE4);
    check("t1_irq", {3'b000, irq}, 8'h04);

    // 2: held level sets IF only once
    write_reg(16'hFF0F, 8'h00);
    src = 5'b00001; tick();
    check("t2_set", {3'b000, irq}, 8'h01);
    tick();
    write_reg(16'hFF0F, 8'hE0);
    for (int i = 0; i < 7; i++) tick();
    check_read("t2_if", 16'hFF0F, 8'hE0);
    check("t2_irq", {3'b000, irq}, 8'h00);

    // 3: two pending, serviced lowest first
    src = 5'b01010; tick();
    check("t3_irq0", {3'b000, irq}, 8'h0A);
    handle = 1'b1; tick();
    check("t3_vec1", vec, 8'h48);
    check_read("t3_if1", 16'hFF0F, 8'hE8);
    tick(); tick();
    check("t3_vec1_hold", vec, 8'h48);
    check_read("t3_if1_hold", 16'hFF0F, 8'hE8);
    check("t3_irq1", {3'b000, irq}, 8'h08);
    handle = 1'b0; tick();
    check("t3_vec_idle", vec, 8'h00);
    handle = 1'b1; tick();
    check("t3_vec2", vec, 8'h58);
    check_read("t3_if2", 16'hFF0F, 8'hE0);
    handle = 1'b0; src = 5'b00000; tick();

    // 4: IE=0, acknowledge with nothing pending
    write_reg(16'hFFFF, 8'h00);
    src = 5'b10000; tick();
    check("t4_irq", {3'b000, irq}, 8'h00);
    handle = 1'b1; tick();
    check("t4_vec", vec, 8'h00);
    check_read("t4_if", 16'hFF0F, 8'hF0);
    handle = 1'b0; src = 5'b00000; tick();
    write_reg(16'hFF0F, 8'h00);

    // 5: new edge on the acknowledged bit wins over the clear
    write_reg(16'hFFFF, 8'h1F);
    src = 5'b00001; tick();
    src = 5'b00000; tick();
    src = 5'b00001; handle = 1'b1; tick();
    check("t5_vec", vec, 8'h40);
    check_read("t5_if", 16'hFF0F, 8'hE1);
    handle = 1'b0; src = 5'b00000; tick();

    // latched address used when no address is presented
    addr = 16'hFFFF; addr_out = 1'b1; tick();
    addr_out = 1'b0; addr = 16'h0000; bus_in = 1'b1; #1;
    check("latched_rd", bus_r, 8'h1F);
    bus_in = 1'b0;

    // clock enable low holds everything
    write_reg(16'hFF0F, 8'h00);
    en = 1'b0; src = 5'b00100; tick();
    check_read("en_hold", 16'hFF0F, 8'hE0);
    en = 1'b1; tick();
    check_read("en_resume", 16'hFF0F, 8'hE4);
    src = 5'b00000; tick();

    // 6: unmapped read, then reset in the middle of an acknowledge
    check_read("t6_unmapped", 16'hC000, 8'h00);
    handle = 1'b1; tick();
    check("t6_vec", vec, 8'h50);
    write_reg(16'hFF0F, 8'h1F);
    check("t6_vec_hold", vec, 8'h50);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_vec", vec, 8'h00);
    check("t6_rst_irq", {3'b000, irq}, 8'h00);
    check_read("t6_rst_bus", 16'hFF0F, 8'h00);
    rst = 1'b0; handle = 1'b0;
    #1;
    check_read("t6_if", 16'hFF0F, 8'hE0);
    check_read("t6_ie", 16'hFFFF, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Memory-mapped responder on the CPU's 8-bit data / 16-bit address bus.
- Owns the IF register at 0xFF0F and the IE register at 0xFFFF.
- Latches rising edges from five peripheral interrupt sources and drives the CPU's 5-bit pending-interrupt input.
- Completes the CPU's interrupt-acknowledge handshake: clears the serviced IF bit and supplies the service vector.

Parameters:
- IF_ADDR, 16'hFF0F, address of the interrupt-flag register
- IE_ADDR, 16'hFFFF, address of the interrupt-enable register
- VECTOR_BASE, 8'h40, vector of source 0; source n vectors to VECTOR_BASE + 8*n

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous reset, active high
- i_Enable  in  1  clock enable; all state updates are gated by it
- i_Address  in  16  CPU address bus
- i_Address_Out  in  1  CPU is presenting a target address
- i_Bus  in  8  CPU write data
- i_Bus_Out  in  1  CPU write strobe
- i_Bus_In  in  1  CPU read strobe
- i_Handle_Interrupt  in  1  CPU acknowledge; high while the CPU services an interrupt
- i_Sources  in  5  request levels: bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad
- o_Bus  out  8  read data; all zeros when not selected, because the CPU ORs bus sources together
- o_Interrupts  out  5  IF[4:0] & IE[4:0]
- o_Ack_Vector  out  8  service vector, valid while in state ACK

Behaviour:
- Reset (async, i_Rst=1):
  - IF=0, IE=0, source history=0, latched address=0, state=IDLE, ack index=0.
  - Outputs: o_Bus=0, o_Interrupts=0, o_Ack_Vector=0.
- Address latch: on an enabled edge with i_Address_Out=1, the latched address takes i_Address.
- Effective address: i_Address when i_Address_Out=1 in the same cycle, otherwise the latched address.
- Read (combinational, zero latency): when i_Bus_In=1 and the effective address matches:
  - IF_ADDR returns {3'b111, IF[4:0]}.
  - IE_ADDR returns IE[7:0].
  - Any other address, or i_Bus_In=0, returns 8'h00.
- Write (on enabled edge with i_Bus_Out=1 and an address match):
  - IF_ADDR: IF gets i_Bus[4:0]; bits 7:5 are discarded.
  - IE_ADDR: IE gets i_Bus[7:0].
- Source edge detect:
  - History register samples i_Sources each enabled edge.
  - A bit where i_Sources=1 and history=0 sets the matching IF bit.
  - A level held high sets IF only once.
- Acknowledge FSM, states IDLE and ACK:
  - IDLE -> ACK on an enabled edge with i_Handle_Interrupt=1.
    - Capture the index of the lowest set bit of o_Interrupts and clear that IF bit on the same edge.
    - If o_Interrupts=0 (request withdrawn), capture "none": no IF bit is cleared and o_Ack_Vector=8'h00.
  - ACK: o_Ack_Vector = VECTOR_BASE + 8*index; stay while i_Handle_Interrupt=1.
  - ACK -> IDLE when i_Handle_Interrupt=0. o_Ack_Vector returns to 0.
  - No further clear happens until i_Handle_Interrupt has been low for at least one enabled edge.
- Same-edge priority on IF, lowest first:
  1. CPU write.
  2. Acknowledge clear.
  3. Source rising-edge set.
  - Consequence: a new edge on the bit being acknowledged leaves that bit set.
- o_Interrupts is combinational from the registered IF and IE.
- i_Enable=0: registers, history and FSM hold; reads still respond combinationally.
- i_Bus_In and i_Bus_Out high together: the write is performed and o_Bus still reflects the pre-edge value.
- Reset asserted mid-acknowledge: FSM goes to IDLE immediately and IF is cleared.

Test Plan:
1. Reset, then write 8'h1F to 0xFFFF, pulse i_Sources[2] for one cycle -> IF read at 0xFF0F returns 8'hE4; o_Interrupts=5'b00100.
2. Hold i_Sources[0]=1 for 10 cycles, write IF=0 at cycle 3 -> IF[0] stays 0 after the write (set only once); o_Interrupts=0.
3. IE=8'h1F, raise sources 1 and 3, assert i_Handle_Interrupt for 3 cycles -> o_Ack_Vector=8'h48; IF=5'b01000 afterwards; o_Interrupts=5'b01000; deassert and reassert the acknowledge -> o_Ack_Vector=8'h58; IF=0.
4. IE=0, source 4 fires, acknowledge -> o_Ack_Vector=8'h00; IF[4] is still 1.
5. Same edge: acknowledge of bit 0 and a new rising edge on i_Sources[0] -> IF[0]=1 after the edge.
6. Read 0xC000 with i_Bus_In=1 -> o_Bus=8'h00. Assert i_Rst during ACK -> o_Ack_Vector=0, IF=0, IE=0 without waiting for a clock edge.
